// File: rtl/stream_dword_serializer_if.sv
// stream_dword_serializer_if
//   Bundles the two handshakes of the dword-to-byte serializer.
//   Upstream dword side:   in_valid, in_ready, in_data[31:0], in_bytes[2:0], in_last
//   Downstream byte side:  stream_in_valid, stream_in_ready, stream_in_data[7:0],
//                          stream_in_last
//   slave  : the serializer (sinks dwords, sources bytes)
//   master : the environment (sources dwords, sinks bytes)
interface stream_dword_serializer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [2:0]  in_bytes;
  logic        in_last;
  logic        stream_in_valid;
  logic        stream_in_ready;
  logic [7:0]  stream_in_data;
  logic        stream_in_last;

  modport slave (
    input  in_valid, in_data, in_bytes, in_last, stream_in_ready,
    output in_ready, stream_in_valid, stream_in_data, stream_in_last
  );

  modport master (
    output in_valid, in_data, in_bytes, in_last, stream_in_ready,
    input  in_ready, stream_in_valid, stream_in_data, stream_in_last
  );
endinterface

// File: rtl/stream_dword_serializer.sv
// stream_dword_serializer
//   Accepts 32-bit dwords carrying 1..4 valid bytes and emits them one byte
//   per handshake, in LSB-first (LSB_FIRST=1) or MSB-first order.
//   Ports:
//     clk, reset  - clock and synchronous active-high reset
//     bus         - dword input / byte output handshakes (slave modport)
//     byte_count  - running count of bytes accepted downstream (wraps)
//     err_len     - sticky flag, set when a dword with in_bytes 0 or >4 arrives
module stream_dword_serializer #(
  parameter int LSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  stream_dword_serializer_if.slave  bus,
  output logic [CNT_W-1:0]          byte_count,
  output logic                      err_len
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  rem_q, rem_d;
  logic        last_q, last_d;
  logic        err_d;

  logic ready_int;
  logic valid_int;
  logic accept;
  logic xfer;
  logic legal;

  // Handshake outputs. in_ready looks only at state, remaining count and the
  // downstream ready so upstream may safely wait on it before raising valid.
  // Reset gates both handshakes combinationally so nothing moves while held.
  always_comb begin
    ready_int = 1'b0;
    if (!reset) begin
      if (state_q == IDLE) ready_int = 1'b1;
      else                 ready_int = (rem_q == 3'd1) && bus.stream_in_ready;
    end
    valid_int = !reset && (state_q == SHIFT);

    bus.in_ready        = ready_int;
    bus.stream_in_valid = valid_int;
    bus.stream_in_data  = (LSB_FIRST != 0) ? data_q[7:0] : data_q[31:24];
    bus.stream_in_last  = valid_int && (rem_q == 3'd1) && last_q;

    accept = bus.in_valid && ready_int;
    xfer   = valid_int && bus.stream_in_ready;
    legal  = (bus.in_bytes >= 3'd1) && (bus.in_bytes <= 3'd4);
  end

  // Next-state logic. A byte transfer shifts the held dword so the current
  // byte always sits at the emitting end. An accept is evaluated after the
  // transfer so the final-byte-plus-reload case overrides the return to IDLE;
  // an illegal dword only raises the error flag and otherwise leaves the
  // transfer's effect in place.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    last_d  = last_q;
    err_d   = err_len;

    if (xfer) begin
      rem_d  = rem_q - 3'd1;
      data_d = (LSB_FIRST != 0) ? {8'h00, data_q[31:8]} : {data_q[23:0], 8'h00};
      if (rem_q == 3'd1) state_d = IDLE;
    end

    if (accept) begin
      if (legal) begin
        state_d = SHIFT;
        data_d  = bus.in_data;
        rem_d   = bus.in_bytes;
        last_d  = bus.in_last;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State and datapath registers; reset discards any partially sent dword.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      data_q     <= 32'h0;
      rem_q      <= 3'd0;
      last_q     <= 1'b0;
      err_len    <= 1'b0;
      byte_count <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      err_len <= err_d;
      if (xfer) byte_count <= byte_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_stream_dword_serializer.sv
// tb_stream_dword_serializer
//   Directed bench for stream_dword_serializer. Two instances share clock and
//   reset: sif drives the default LSB-first / 16-bit counter build, mif drives
//   an MSB-first build with a 3-bit counter so wrap-around is reachable.
//   Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_stream_dword_serializer;
  logic        clk;
  logic        reset;
  logic [15:0] byte_count;
  logic        err_len;
  logic [2:0]  m_byte_count;
  logic        m_err_len;

  int errors;
  int checks;
  int exp_cnt;

  stream_dword_serializer_if sif ();
  stream_dword_serializer_if mif ();

  stream_dword_serializer #(.LSB_FIRST(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(sif), .byte_count(byte_count), .err_len(err_len)
  );

  stream_dword_serializer #(.LSB_FIRST(0), .CNT_W(3)) dut_msb (
    .clk(clk), .reset(reset), .bus(mif), .byte_count(m_byte_count), .err_len(m_err_len)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reset holds every handshake low and clears status; in_ready rises after release.
  task automatic test_reset();
    reset = 1'b1;
    sif.in_valid = 1'b0; sif.in_data = 32'h0; sif.in_bytes = 3'd0; sif.in_last = 1'b0;
    sif.stream_in_ready = 1'b1;
    mif.in_valid = 1'b0; mif.in_data = 32'h0; mif.in_bytes = 3'd0; mif.in_last = 1'b0;
    mif.stream_in_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (sif.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_ready: got %b expected 0", sif.in_ready); end
    checks++; if (sif.stream_in_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b expected 0", sif.stream_in_valid); end
    checks++; if (sif.stream_in_last !== 1'b0) begin errors++; $display("[TB] FAIL rst_last: got %b expected 0", sif.stream_in_last); end
    checks++; if (byte_count !== 16'd0) begin errors++; $display("[TB] FAIL rst_count: got %0d expected 0", byte_count); end
    checks++; if (err_len !== 1'b0) begin errors++; $display("[TB] FAIL rst_err: got %b expected 0", err_len); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk); #1;
    checks++; if (sif.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_in_ready: got %b expected 1", sif.in_ready); end
    checks++; if (sif.stream_in_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_valid: got %b expected 0", sif.stream_in_valid); end
    exp_cnt = 0;
  endtask

  // Full 4-byte dword, LSB first, last flag only on the final byte.
  task automatic test_basic();
    logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    @(negedge clk);
    sif.in_valid = 1'b1; sif.in_data = 32'h44332211; sif.in_bytes = 3'd4; sif.in_last = 1'b1;
    sif.stream_in_ready = 1'b1;
    #1;
    checks++; if (sif.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_accept_ready: got %b expected 1", sif.in_ready); end
    @(negedge clk); sif.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (sif.stream_in_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid%0d: got %b expected 1", i, sif.stream_in_valid); end
      checks++; if (sif.stream_in_data !== exp_b[i]) begin errors++; $display("[TB] FAIL basic_data%0d: got %h expected %h", i, sif.stream_in_data, exp_b[i]); end
      checks++; if (sif.stream_in_last !== (i == 3)) begin errors++; $display("[TB] FAIL basic_last%0d: got %b expected %b", i, sif.stream_in_last, (i == 3)); end
      @(negedge clk);
    end
    #1;
    exp_cnt += 4;
    checks++; if (sif.stream_in_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle: got %b expected 0", sif.stream_in_valid); end
    checks++; if (byte_count !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL basic_count: got %0d expected %0d", byte_count, exp_cnt); end
  endtask

  // Two 2-byte dwords with the second accepted on the first dword's final byte.
  task automatic test_back_to_back();
    logic [7:0] exp_b  [4] = '{8'hBB, 8'hAA, 8'hDD, 8'hCC};
    logic       exp_rd [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       exp_ls [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    @(negedge clk);
    sif.in_valid = 1'b1; sif.in_data = 32'h0000AABB; sif.in_bytes = 3'd2; sif.in_last = 1'b0;
    @(negedge clk);
    sif.in_data = 32'h0000CCDD; sif.in_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) sif.in_valid = 1'b0;
      #1;
      checks++; if (sif.stream_in_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid%0d: got %b expected 1", i, sif.stream_in_valid); end
      checks++; if (sif.stream_in_data !== exp_b[i]) begin errors++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", i, sif.stream_in_data, exp_b[i]); end
      checks++; if (sif.in_ready !== exp_rd[i]) begin errors++; $display("[TB] FAIL b2b_in_ready%0d: got %b expected %b", i, sif.in_ready, exp_rd[i]); end
      checks++; if (sif.stream_in_last !== exp_ls[i]) begin errors++; $display("[TB] FAIL b2b_last%0d: got %b expected %b", i, sif.stream_in_last, exp_ls[i]); end
      @(negedge clk);
    end
    #1;
    exp_cnt += 4;
    checks++; if (sif.stream_in_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle: got %b expected 0", sif.stream_in_valid); end
    checks++; if (byte_count !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected %0d", byte_count, exp_cnt); end
  endtask

  // Downstream stalls mid-dword; the presented byte must hold until taken.
  task automatic test_backpressure();
    logic       pat   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] exp_b [3] = '{8'h0A, 8'h0B, 8'h0C};
    int idx;
    idx = 0;
    @(negedge clk);
    sif.in_valid = 1'b1; sif.in_data = 32'h0D0C0B0A; sif.in_bytes = 3'd3; sif.in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      sif.in_valid = 1'b0;
      sif.stream_in_ready = pat[c];
      #1;
      checks++; if (sif.stream_in_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid%0d: got %b expected 1", c, sif.stream_in_valid); end
      checks++; if (sif.stream_in_data !== exp_b[idx]) begin errors++; $display("[TB] FAIL bp_data%0d: got %h expected %h", c, sif.stream_in_data, exp_b[idx]); end
      checks++; if (sif.stream_in_last !== (idx == 2)) begin errors++; $display("[TB] FAIL bp_last%0d: got %b expected %b", c, sif.stream_in_last, (idx == 2)); end
      if (pat[c]) idx++;
    end
    @(negedge clk);
    sif.stream_in_ready = 1'b1;
    #1;
    exp_cnt += 3;
    checks++; if (sif.stream_in_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_idle: got %b expected 0", sif.stream_in_valid); end
    checks++; if (byte_count !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL bp_count: got %0d expected %0d", byte_count, exp_cnt); end
  endtask

  // Lengths 0 and 5 are dropped and flag err_len; legal traffic still flows,
  // including an illegal dword offered on a final byte (block must go idle).
  task automatic test_illegal_len();
    @(negedge clk);
    sif.in_valid = 1'b1; sif.in_data = 32'h12345678; sif.in_bytes = 3'd0; sif.in_last = 1'b1;
    @(negedge clk);
    sif.in_bytes = 3'd5;
    #1;
    checks++; if (sif.stream_in_valid !== 1'b0) begin errors++; $display("[TB] FAIL ill0_valid: got %b expected 0", sif.stream_in_valid); end
    checks++; if (err_len !== 1'b1) begin errors++; $display("[TB] FAIL ill0_err: got %b expected 1", err_len); end
    @(negedge clk);
    sif.in_valid = 1'b0;
    #1;
    checks++; if (sif.stream_in_valid !== 1'b0) begin errors++; $display("[TB] FAIL ill5_valid: got %b expected 0", sif.stream_in_valid); end
    checks++; if (byte_count !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL ill_count: got %0d expected %0d", byte_count, exp_cnt); end
    @(negedge clk);
    sif.in_valid = 1'b1; sif.in_data = 32'h00005566; sif.in_bytes = 3'd2; sif.in_last = 1'b1;
    @(negedge clk);
    sif.in_valid = 1'b0;
    #1;
    checks++; if (sif.stream_in_data !== 8'h66) begin errors++; $display("[TB] FAIL ill_after_b0: got %h expected 66", sif.stream_in_data); end
    @(negedge clk); #1;
    checks++; if (sif.stream_in_data !== 8'h55 || sif.stream_in_last !== 1'b1) begin errors++; $display("[TB] FAIL ill_after_b1: got %h/%b expected 55/1", sif.stream_in_data, sif.stream_in_last); end
    @(negedge clk);
    sif.in_valid = 1'b1; sif.in_data = 32'h00000077; sif.in_bytes = 3'd1; sif.in_last = 1'b1;
    @(negedge clk);
    sif.in_bytes = 3'd7;
    #1;
    checks++; if (sif.stream_in_data !== 8'h77 || sif.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ill_reload_byte: got %h/%b expected 77/1", sif.stream_in_data, sif.in_ready); end
    @(negedge clk);
    sif.in_valid = 1'b0;
    #1;
    exp_cnt += 3;
    checks++; if (sif.stream_in_valid !== 1'b0) begin errors++; $display("[TB] FAIL ill_reload_idle: got %b expected 0", sif.stream_in_valid); end
    checks++; if (err_len !== 1'b1) begin errors++; $display("[TB] FAIL ill_err_sticky: got %b expected 1", err_len); end
    checks++; if (byte_count !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL ill_final_count: got %0d expected %0d", byte_count, exp_cnt); end
  endtask

  // Reset after two of four bytes; leftovers vanish and the next dword starts clean.
  task automatic test_reset_mid();
    @(negedge clk);
    sif.in_valid = 1'b1; sif.in_data = 32'h44332211; sif.in_bytes = 3'd4; sif.in_last = 1'b1;
    @(negedge clk);
    sif.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (sif.stream_in_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_valid: got %b expected 0", sif.stream_in_valid); end
    checks++; if (byte_count !== 16'd0) begin errors++; $display("[TB] FAIL rmid_count: got %0d expected 0", byte_count); end
    checks++; if (err_len !== 1'b0) begin errors++; $display("[TB] FAIL rmid_err: got %b expected 0", err_len); end
    checks++; if (sif.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmid_in_ready: got %b expected 1", sif.in_ready); end
    @(negedge clk);
    sif.in_valid = 1'b1; sif.in_data = 32'h00009988; sif.in_bytes = 3'd2; sif.in_last = 1'b1;
    @(negedge clk);
    sif.in_valid = 1'b0;
    #1;
    checks++; if (sif.stream_in_data !== 8'h88 || sif.stream_in_valid !== 1'b1) begin errors++; $display("[TB] FAIL rmid_first: got %h/%b expected 88/1", sif.stream_in_data, sif.stream_in_valid); end
    @(negedge clk); #1;
    checks++; if (sif.stream_in_data !== 8'h99 || sif.stream_in_last !== 1'b1) begin errors++; $display("[TB] FAIL rmid_second: got %h/%b expected 99/1", sif.stream_in_data, sif.stream_in_last); end
    @(negedge clk); #1;
    checks++; if (byte_count !== 16'd2 || sif.stream_in_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_done: got %0d/%b expected 2/0", byte_count, sif.stream_in_valid); end
  endtask

  // MSB-first build: byte order, partial dwords and 3-bit counter wrap (8 -> 0).
  task automatic test_msb_first();
    logic [31:0] dw   [3] = '{32'h01020304, 32'hA0B0C0D0, 32'hEE000000};
    logic [2:0]  nb   [3] = '{3'd3, 3'd4, 3'd1};
    logic [2:0]  cnt  [3] = '{3'd3, 3'd7, 3'd0};
    logic [7:0]  exp_b[8] = '{8'h01, 8'h02, 8'h03, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hEE};
    int k;
    k = 0;
    for (int d = 0; d < 3; d++) begin
      @(negedge clk);
      mif.in_valid = 1'b1; mif.in_data = dw[d]; mif.in_bytes = nb[d]; mif.in_last = 1'b1;
      @(negedge clk);
      mif.in_valid = 1'b0;
      for (int i = 0; i < int'(nb[d]); i++) begin
        #1;
        checks++; if (mif.stream_in_valid !== 1'b1 || mif.stream_in_data !== exp_b[k]) begin errors++; $display("[TB] FAIL msb_data%0d: got %h/%b expected %h/1", k, mif.stream_in_data, mif.stream_in_valid, exp_b[k]); end
        checks++; if (mif.stream_in_last !== (i == int'(nb[d]) - 1)) begin errors++; $display("[TB] FAIL msb_last%0d: got %b expected %b", k, mif.stream_in_last, (i == int'(nb[d]) - 1)); end
        k++;
        @(negedge clk);
      end
      #1;
      checks++; if (mif.stream_in_valid !== 1'b0) begin errors++; $display("[TB] FAIL msb_idle%0d: got %b expected 0", d, mif.stream_in_valid); end
      checks++; if (m_byte_count !== cnt[d]) begin errors++; $display("[TB] FAIL msb_count%0d: got %0d expected %0d", d, m_byte_count, cnt[d]); end
    end
    checks++; if (m_err_len !== 1'b0) begin errors++; $display("[TB] FAIL msb_err: got %b expected 0", m_err_len); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    exp_cnt = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_illegal_len();
    test_reset_mid();
    test_msb_first();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_dword_serializer.md
STREAM_DWORD_SERIALIZER -- requirements
Module: stream_dword_serializer

Interface
REQ-001 The block SHALL have parameter LSB_FIRST, default 1, meaning byte 0 (data[7:0]) is emitted first; when 0, data[31:24] is emitted first.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the byte counter.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge only.
REQ-004 Port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port in_valid, input, 1 bit: upstream dword is valid.
REQ-006 Port in_ready, output, 1 bit: the block accepts the dword this cycle.
REQ-007 Port in_data, input, 32 bits: dword payload.
REQ-008 Port in_bytes, input, 3 bits: number of valid bytes, 1..4; valid bytes are packed from the first-emitted end.
REQ-009 Port in_last, input, 1 bit: the dword ends a packet.
REQ-010 Port stream_in_valid, output, 1 bit: byte valid toward the downstream stage.
REQ-011 Port stream_in_ready, input, 1 bit: downstream accepts the byte.
REQ-012 Port stream_in_data, output, 8 bits: byte payload.
REQ-013 Port stream_in_last, output, 1 bit: final byte of a packet.
REQ-014 Port byte_count, output, CNT_W bits: total bytes accepted downstream.
REQ-015 Port err_len, output, 1 bit: sticky flag indicating an illegal in_bytes value was received.

Function
REQ-016 The block SHALL perform a dword accept when in_valid and in_ready are both 1 on a rising edge, and a byte transfer when stream_in_valid and stream_in_ready are both 1.
REQ-017 The block SHALL implement two states, IDLE (no dword held) and SHIFT (dword held, bytes pending).
REQ-018 In IDLE, in_ready SHALL be 1 and stream_in_valid SHALL be 0.
REQ-019 A legal dword accept in IDLE SHALL latch data, in_bytes and in_last, set the remaining count to in_bytes, and enter SHIFT; the first byte SHALL be valid on the next cycle (latency 1).
REQ-020 In SHIFT, stream_in_valid SHALL be 1, stream_in_data SHALL be the current byte in LSB_FIRST order, and stream_in_last SHALL equal (remaining==1 and held last).
REQ-021 Each byte transfer SHALL decrement the remaining count and advance to the next byte.
REQ-022 In SHIFT, in_ready SHALL equal (remaining==1 and stream_in_ready), which allows back-to-back dwords with no bubble byte.
REQ-023 When the final byte transfers and there is no simultaneous accept, the block SHALL return to IDLE; when there is a simultaneous accept, it SHALL reload and stay in SHIFT.
REQ-024 When stream_in_ready is 0 in SHIFT, stream_in_data, stream_in_last and stream_in_valid SHALL be held stable.
REQ-025 An accepted dword with in_bytes of 0 or greater than 4 SHALL be dropped, SHALL set err_len, SHALL emit nothing, and SHALL leave the state unchanged (IDLE stays IDLE; in the SHIFT-reload case the block goes to IDLE).
REQ-026 byte_count SHALL increment by 1 per byte transfer and SHALL wrap modulo 2^CNT_W.
REQ-027 in_ready SHALL be a function only of state, remaining count and stream_in_ready, and SHALL have no dependency on in_valid.

Reset
REQ-028 While reset is 1, the block SHALL hold IDLE, force stream_in_valid=0 and stream_in_last=0, hold in_ready=0, and clear byte_count and err_len to 0.
REQ-029 On the cycle after reset deasserts, in_ready SHALL be 1.
REQ-030 If reset is asserted mid-dword, the pending bytes SHALL be discarded and no partial byte SHALL be emitted afterwards.

Verification
REQ-031 Basic dword: with LSB_FIRST=1, in_data=0x44332211, in_bytes=4, in_last=1, and stream_in_ready held at 1, the block SHALL emit bytes 0x11, 0x22, 0x33, 0x44 on cycles 1-4, SHALL assert stream_in_last only on 0x44, and SHALL end with byte_count=4.
REQ-032 Back-to-back: with two dwords of 2 bytes each (0xAABB, then 0xCCDD) and stream_in_ready held at 1, the block SHALL emit 0xBB, 0xAA, 0xDD, 0xCC on consecutive cycles with no gap, and in_ready SHALL pulse on the cycle 0xAA is emitted.
REQ-033 Backpressure: with stream_in_ready toggled 1,0,0,1 during a dword, the byte SHALL stay stable while stream_in_ready is 0, no byte SHALL be lost or duplicated, and byte_count SHALL equal the number of handshakes.
REQ-034 MSB-first: with LSB_FIRST=0, in_data=0x01020304 and in_bytes=3, the block SHALL emit 0x01, 0x02, 0x03.
REQ-035 Illegal length: with in_bytes=0 and then in_bytes=5, the block SHALL emit no bytes, err_len SHALL be 1 and stay 1 until reset, and a following legal dword SHALL still be serialized correctly.
REQ-036 Reset mid-operation: asserting reset after 2 of 4 bytes SHALL bring stream_in_valid low the next cycle, byte_count SHALL become 0, and a new dword SHALL start from its first byte.
